// File: rtl/midi_uart_note_tracker.sv
// Serial MIDI input to held-key bitmap: UART receiver, note-on/off parser with
// running status and channel filter, plus registered popcount/sole-key summary.
module midi_uart_note_tracker #(
  parameter int          CLK_HZ       = 100_000_000,
  parameter int          BAUD         = 31_250,
  parameter int          NUM_KEYS     = 88,
  parameter int          KEY_BASE     = 21,
  parameter logic [15:0] CHANNEL_MASK = 16'hFFFF
) (
  input  logic                          clk_100mhz,
  input  logic                          reset,
  input  logic                          rx_in,
  output logic [7:0]                    byte_out,
  output logic                          byte_valid,
  output logic                          framing_err,
  output logic                          event_valid,
  output logic [6:0]                    event_note,
  output logic                          event_on,
  output logic [NUM_KEYS-1:0]           notes_held,
  output logic [$clog2(NUM_KEYS+1)-1:0] held_count,
  output logic [6:0]                    single_note
);

  localparam int BIT_CYCLES = CLK_HZ / BAUD;
  localparam int HALF_BIT   = BIT_CYCLES / 2;
  localparam int CNTW       = $clog2(BIT_CYCLES + 1);
  localparam int CW         = $clog2(NUM_KEYS + 1);

  typedef enum logic [2:0] {U_IDLE, U_START, U_DATA, U_STOP, U_WAIT_HIGH} uart_state_t;
  typedef enum logic [1:0] {WAIT_STATUS, WAIT_NOTE, WAIT_VEL} parse_state_t;

  logic rx_meta, rx_s;

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  uart_state_t     u_state, u_next;
  logic [CNTW-1:0] cnt, cnt_next;
  logic [7:0]      shift, shift_next;
  logic [2:0]      bit_idx, bit_idx_next;
  logic [7:0]      byte_next;
  logic            bv_next, fe_next;

  // Bit timer counts down to zero; each zero is a sampling point.
  always_comb begin
    u_next       = u_state;
    cnt_next     = cnt;
    shift_next   = shift;
    bit_idx_next = bit_idx;
    byte_next    = byte_out;
    bv_next      = 1'b0;
    fe_next      = 1'b0;
    case (u_state)
      U_IDLE: begin
        if (!rx_s) begin
          u_next   = U_START;
          cnt_next = CNTW'(HALF_BIT - 1);
        end
      end
      U_START: begin
        if (cnt == '0) begin
          if (!rx_s) begin
            u_next       = U_DATA;
            cnt_next     = CNTW'(BIT_CYCLES - 1);
            bit_idx_next = 3'd0;
          end else begin
            u_next = U_IDLE;
          end
        end else begin
          cnt_next = cnt - CNTW'(1);
        end
      end
      U_DATA: begin
        if (cnt == '0) begin
          shift_next = {rx_s, shift[7:1]};
          cnt_next   = CNTW'(BIT_CYCLES - 1);
          if (bit_idx == 3'd7) u_next = U_STOP;
          else bit_idx_next = bit_idx + 3'd1;
        end else begin
          cnt_next = cnt - CNTW'(1);
        end
      end
      U_STOP: begin
        if (cnt == '0) begin
          if (rx_s) begin
            byte_next = shift;
            bv_next   = 1'b1;
            u_next    = U_IDLE;
          end else begin
            fe_next = 1'b1;
            u_next  = U_WAIT_HIGH;
          end
        end else begin
          cnt_next = cnt - CNTW'(1);
        end
      end
      U_WAIT_HIGH: if (rx_s) u_next = U_IDLE;
      default: u_next = U_IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      u_state     <= U_IDLE;
      cnt         <= '0;
      shift       <= '0;
      bit_idx     <= '0;
      byte_out    <= '0;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      u_state     <= u_next;
      cnt         <= cnt_next;
      shift       <= shift_next;
      bit_idx     <= bit_idx_next;
      byte_out    <= byte_next;
      byte_valid  <= bv_next;
      framing_err <= fe_next;
    end
  end

  parse_state_t        p_state, p_next;
  logic                rs_valid, rs_valid_next, rs_on, rs_on_next;
  logic [6:0]          note_q, note_next;
  logic                ev_valid_next, ev_on_next, on_c, in_range;
  logic [6:0]          ev_note_next, idx_c;
  logic [NUM_KEYS-1:0] held_next;
  int                  note_i, idx_i;

  always_comb begin
    p_next        = p_state;
    rs_valid_next = rs_valid;
    rs_on_next    = rs_on;
    note_next     = note_q;
    ev_valid_next = 1'b0;
    ev_note_next  = event_note;
    ev_on_next    = event_on;
    held_next     = notes_held;
    note_i        = {25'd0, note_q};
    idx_i         = note_i - KEY_BASE;
    in_range      = (idx_i >= 0) && (idx_i < NUM_KEYS);
    idx_c         = idx_i[6:0];
    on_c          = rs_on && (byte_out[6:0] != 7'd0);
    if (byte_valid && byte_out < 8'hF8) begin
      if (byte_out[7]) begin
        if (byte_out[7:5] == 3'b100 && CHANNEL_MASK[byte_out[3:0]]) begin
          rs_valid_next = 1'b1;
          rs_on_next    = byte_out[4];
          p_next        = WAIT_NOTE;
        end else begin
          rs_valid_next = 1'b0;
          p_next        = WAIT_STATUS;
        end
      end else begin
        case (p_state)
          WAIT_STATUS: begin
            if (rs_valid) begin
              note_next = byte_out[6:0];
              p_next    = WAIT_VEL;
            end
          end
          WAIT_NOTE: begin
            note_next = byte_out[6:0];
            p_next    = WAIT_VEL;
          end
          WAIT_VEL: begin
            p_next = WAIT_NOTE;
            if (in_range) begin
              ev_valid_next = 1'b1;
              ev_note_next  = idx_c;
              ev_on_next    = on_c;
              for (int i = 0; i < NUM_KEYS; i++)
                if (idx_c == 7'(i)) held_next[i] = on_c;
            end
          end
          default: p_next = WAIT_STATUS;
        endcase
      end
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      p_state     <= WAIT_STATUS;
      rs_valid    <= 1'b0;
      rs_on       <= 1'b0;
      note_q      <= '0;
      event_valid <= 1'b0;
      event_note  <= '0;
      event_on    <= 1'b0;
      notes_held  <= '0;
    end else begin
      p_state     <= p_next;
      rs_valid    <= rs_valid_next;
      rs_on       <= rs_on_next;
      note_q      <= note_next;
      event_valid <= ev_valid_next;
      event_note  <= ev_note_next;
      event_on    <= ev_on_next;
      notes_held  <= held_next;
    end
  end

  logic [CW-1:0] count_c;
  logic [6:0]    last_c, single_c;

  always_comb begin
    count_c = '0;
    last_c  = 7'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (notes_held[i]) begin
        count_c = count_c + CW'(1);
        last_c  = 7'(i);
      end
    end
    if (count_c == '0)          single_c = 7'h7F;
    else if (count_c == CW'(1)) single_c = last_c;
    else                        single_c = 7'h7E;
  end

  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      held_count  <= '0;
      single_note <= 7'h7F;
    end else begin
      held_count  <= count_c;
      single_note <= single_c;
    end
  end

endmodule
